// File: rtl/minicpu_pkg.sv
// Shared constants and types for the minicpu data-side responder:
// MMIO address map, STATUS bit layout and UART transmitter encodings.
package minicpu_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [BUS_W-1:0] LED_ADDR    = 32'hBFAF_0000;
  localparam logic [BUS_W-1:0] SW_ADDR     = 32'hBFAF_0004;
  localparam logic [BUS_W-1:0] CYCLE_ADDR  = 32'hBFAF_0008;
  localparam logic [BUS_W-1:0] TXDATA_ADDR = 32'hBFAF_000C;
  localparam logic [BUS_W-1:0] STATUS_ADDR = 32'hBFAF_0010;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = FIFO_AW + 1;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned BIT_W      = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             busy;
    logic             empty;
    logic             full;
  } uart_status_t;

  // Word-granular match of an MMIO register; the byte offset is ignored.
  function automatic logic mmio_hit(input logic [BUS_W-1:0] addr,
                                    input logic [BUS_W-1:0] base);
    return addr[BUS_W-1:2] == base[BUS_W-1:2];
  endfunction

endpackage

// File: rtl/minicpu_data_responder_if.sv
// CPU data-SRAM port: single-cycle write strobe with combinational read data.
interface minicpu_data_responder_if;
  import minicpu_pkg::*;

  logic             data_sram_we;
  logic [BUS_W-1:0] data_sram_addr;
  logic [BUS_W-1:0] data_sram_wdata;
  logic [BUS_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_we,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/minicpu_uart_tx.sv
// 8-entry byte FIFO feeding an 8N1 serialiser; each bit lasts CLK_DIV clocks.
module minicpu_uart_tx
  import minicpu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [7:0]   push_data,
  input  logic         clr_ovf,
  output uart_status_t status_c,
  output logic         txd
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  tx_state_t          state;
  tx_state_t          state_d;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [BIT_W-1:0]   bit_q;
  logic [BIT_W-1:0]   bit_d;
  logic [7:0]         frame_q;
  logic [7:0]         frame_d;
  logic               txd_d;

  logic               full_c;
  logic               empty_c;
  logic               push_ok_c;
  logic               pop_c;

  // Fullness is judged on the pre-pop count, so a push meeting a pop at 8 is lost.
  assign full_c    = count == CNT_W'(FIFO_DEPTH);
  assign empty_c   = count == '0;
  assign push_ok_c = push && !full_c;

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      if (clr_ovf)         overflow <= 1'b0;
      if (push && full_c)  overflow <= 1'b1;
    end
  end

  // Serialiser state register; txd is registered from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= TX_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      txd     <= txd_d;
    end
  end

  always_comb begin
    state_d = state;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    pop_c   = 1'b0;
    txd_d   = 1'b1;

    case (state)
      TX_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          frame_d = mem[rd_ptr];
          state_d = TX_START;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      TX_START: begin
        if (div_q == DIV_LAST) begin
          state_d = TX_DATA;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_W'(7)) begin
            state_d = TX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (div_q == DIV_LAST) begin
          state_d = TX_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = frame_d[bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  assign status_c.count    = count;
  assign status_c.overflow = overflow;
  assign status_c.busy     = state != TX_IDLE;
  assign status_c.empty    = empty_c;
  assign status_c.full     = full_c;

endmodule

// File: rtl/minicpu_data_responder.sv
// Data-side responder for the minicpu: word RAM plus LED, switch, cycle
// counter and UART MMIO registers, all read back combinationally.
module minicpu_data_responder
  import minicpu_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned CLK_DIV   = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  minicpu_data_responder_if.slave        bus,
  input  logic [7:0]                     sw,
  output logic [15:0]                    led,
  output logic                           uart_txd
);

  localparam int unsigned      RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [BUS_W-1:0] RAM_BYTES = BUS_W'(RAM_WORDS * 4);

  logic [BUS_W-1:0]  ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_c;
  logic              ram_sel_c;
  logic              led_sel_c;
  logic              sw_sel_c;
  logic              cycle_sel_c;
  logic              tx_sel_c;
  logic              status_sel_c;

  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [BUS_W-1:0]  cycle_cnt;
  uart_status_t      tx_status_c;
  logic [BUS_W-1:0]  status_word_c;
  logic              tx_push_c;
  logic              tx_clr_ovf_c;

  assign ram_sel_c    = bus.data_sram_addr < RAM_BYTES;
  assign ram_idx_c    = bus.data_sram_addr[RAM_AW+1:2];
  assign led_sel_c    = mmio_hit(bus.data_sram_addr, LED_ADDR);
  assign sw_sel_c     = mmio_hit(bus.data_sram_addr, SW_ADDR);
  assign cycle_sel_c  = mmio_hit(bus.data_sram_addr, CYCLE_ADDR);
  assign tx_sel_c     = mmio_hit(bus.data_sram_addr, TXDATA_ADDR);
  assign status_sel_c = mmio_hit(bus.data_sram_addr, STATUS_ADDR);

  assign tx_push_c    = bus.data_sram_we && tx_sel_c;
  assign tx_clr_ovf_c = bus.data_sram_we && status_sel_c && bus.data_sram_wdata[STAT_OVF_BIT];

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bus.data_sram_we && ram_sel_c) ram[ram_idx_c] <= bus.data_sram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led       <= '0;
      cycle_cnt <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (bus.data_sram_we && led_sel_c) led <= bus.data_sram_wdata[15:0];
      if (bus.data_sram_we && cycle_sel_c) cycle_cnt <= '0;
      else                                 cycle_cnt <= cycle_cnt + BUS_W'(1);
    end
  end

  // Zero-latency read mux; unmapped addresses and TXDATA read as zero.
  always_comb begin
    status_word_c                                = '0;
    status_word_c[STAT_FULL_BIT]                 = tx_status_c.full;
    status_word_c[STAT_EMPTY_BIT]                = tx_status_c.empty;
    status_word_c[STAT_BUSY_BIT]                 = tx_status_c.busy;
    status_word_c[STAT_OVF_BIT]                  = tx_status_c.overflow;
    status_word_c[STAT_COUNT_LSB +: CNT_W]       = tx_status_c.count;

    bus.data_sram_rdata = '0;
    if (ram_sel_c)         bus.data_sram_rdata = ram[ram_idx_c];
    else if (led_sel_c)    bus.data_sram_rdata = BUS_W'(led);
    else if (sw_sel_c)     bus.data_sram_rdata = BUS_W'(sw_sync);
    else if (cycle_sel_c)  bus.data_sram_rdata = cycle_cnt;
    else if (status_sel_c) bus.data_sram_rdata = status_word_c;
  end

  minicpu_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk       (clk),
    .resetn    (resetn),
    .push      (tx_push_c),
    .push_data (bus.data_sram_wdata[7:0]),
    .clr_ovf   (tx_clr_ovf_c),
    .status_c  (tx_status_c),
    .txd       (uart_txd)
  );

endmodule

// File: tb/tb_minicpu_data_responder.sv
// Scoreboard bench for minicpu_data_responder: bus reads checked against
// queued expectations, UART frames decoded and matched to queued bytes.
module tb_minicpu_data_responder;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned RAM_WORDS = 1024;

  localparam logic [31:0] A_LED = 32'hBFAF_0000;
  localparam logic [31:0] A_SW  = 32'hBFAF_0004;
  localparam logic [31:0] A_CYC = 32'hBFAF_0008;
  localparam logic [31:0] A_TX  = 32'hBFAF_000C;
  localparam logic [31:0] A_ST  = 32'hBFAF_0010;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        uart_txd;

  minicpu_data_responder_if bus ();

  minicpu_data_responder #(
    .RAM_WORDS (RAM_WORDS),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .sw       (sw),
    .led      (led),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  int unsigned tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  tx_q  [$];
  int          frames_rx = 0;
  int unsigned start_cyc = 0;
  int unsigned t0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [7:0] d);
    logic [63:0] r;
    logic        v;
    r = '0;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = 1'b1;
      else             v = d[b-1];
      for (int k = 0; k < int'(CLK_DIV); k++) r[b*CLK_DIV + k] = v;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.data_sram_we    = 1'b1;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = d;
    @(negedge clk);
    bus.data_sram_we    = 1'b0;
    bus.data_sram_wdata = '0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.data_sram_we   = 1'b0;
    bus.data_sram_addr = a;
    exp_q.push_back(exp);
    #1;
    check_val(tag, 64'(bus.data_sram_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
  endtask

  // UART receiver: one sample per clock across the whole frame.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_txd === 1'b0) begin
        logic [63:0] s;
        logic        aborted;
        int unsigned t;
        s       = '0;
        aborted = 1'b0;
        t       = tb_cyc;
        s[0]    = uart_txd;
        for (int i = 1; i < int'(10 * CLK_DIV); i++) begin
          @(negedge clk);
          if (resetn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[i] = uart_txd;
        end
        if (!aborted) begin
          frames_rx++;
          start_cyc = t;
          check_val("frame_expected", 64'(tx_q.size() != 0), 64'd1);
          if (tx_q.size() != 0) check_val("frame_bits", s, frame_bits(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_sram_we    = 1'b0;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    sw                  = 8'h5A;
    resetn              = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values, read while reset is still asserted.
    check_val("rst_led_port", 64'(led), 64'h0);
    check_val("rst_txd", 64'(uart_txd), 64'h1);
    bus_read("rst_led", A_LED, 32'h0);
    bus_read("rst_status", A_ST, 32'h0000_0002);
    bus_read("rst_cycle", A_CYC, 32'h0);
    bus_read("rst_sw", A_SW, 32'h0);

    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Two-flop switch synchroniser latency.
    sw = 8'hC3;
    bus_read("sw_lat0", A_SW, 32'h0000_005A);
    bus_read("sw_lat1", A_SW, 32'h0000_005A);
    bus_read("sw_lat2", A_SW, 32'h0000_00C3);

    // RAM.
    bus_write(32'h0000_0014, 32'hDEAD_BEEF);
    bus_write(32'h0000_0010, 32'h1234_5678);
    bus_read("ram_wr", 32'h0000_0010, 32'h1234_5678);
    bus_read("ram_neighbour", 32'h0000_0014, 32'hDEAD_BEEF);
    bus_read("ram_lowbits", 32'h0000_0013, 32'h1234_5678);
    bus_write(32'h0000_0000, 32'h1111_1111);
    bus_write(RAM_WORDS * 4, 32'h2222_2222);
    bus_read("ram_past_end", RAM_WORDS * 4, 32'h0);
    bus_read("ram_no_alias", 32'h0000_0000, 32'h1111_1111);
    bus_write(RAM_WORDS * 4 - 4, 32'hA5A5_0F0F);
    bus_read("ram_last", RAM_WORDS * 4 - 4, 32'hA5A5_0F0F);

    // LED and unmapped space.
    bus_write(A_LED, 32'hFFFF_ABCD);
    check_val("led_port", 64'(led), 64'hABCD);
    bus_read("led_rd", A_LED, 32'h0000_ABCD);
    bus_read("unmapped_rd", 32'h8000_0000, 32'h0);
    bus_read("txdata_rd", A_TX, 32'h0);
    bus_write(32'h8000_0000, 32'h0000_1234);
    bus_read("unmapped_wr", A_LED, 32'h0000_ABCD);

    // Cycle counter clear and count.
    repeat (100) @(negedge clk);
    bus_write(A_CYC, 32'h5555_5555);
    bus_read("cycle_c1", A_CYC, 32'h0);
    bus_read("cycle_c2", A_CYC, 32'h1);
    bus_read("cycle_c3", A_CYC, 32'h2);

    // Single frame with busy tracking.
    t0 = tb_cyc;
    tx_q.push_back(8'hA5);
    bus_write(A_TX, 32'hFFFF_FFA5);
    bus_read("st_queued", A_ST, 32'h0000_0010);
    for (int k = 0; k < int'(10 * CLK_DIV); k++) bus_read("st_busy", A_ST, 32'h0000_0006);
    bus_read("st_done", A_ST, 32'h0000_0002);
    check_val("start_lat", 64'(start_cyc), 64'(t0 + 2));
    check_val("frames_one", 64'(frames_rx), 64'd1);

    // Overflow: ten writes, nine accepted.
    t0 = tb_cyc;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_q.push_back(8'(8'h30 + i));
      bus_write(A_TX, 32'(8'h30 + i));
    end
    bus_read("st_ovf", A_ST, 32'h0000_008D);
    bus_write(A_ST, 32'h0000_0008);
    bus_read("st_ovf_clr", A_ST, 32'h0000_0085);
    // Push on the cycle the full FIFO pops: must be dropped.
    for (int n = 0; n < 100 && tb_cyc != t0 + 42; n++) @(negedge clk);
    check_val("pop_cycle_reached", 64'(tb_cyc), 64'(t0 + 42));
    bus_write(A_TX, 32'h0000_00EE);
    bus_read("st_full_pop", A_ST, 32'h0000_007C);
    bus_write(A_ST, 32'h0000_0008);
    for (int n = 0; n < 2000 && frames_rx < 10; n++) @(negedge clk);
    check_val("frames_all", 64'(frames_rx), 64'd10);
    check_val("txq_empty", 64'(tx_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    bus_read("st_idle", A_ST, 32'h0000_0002);

    // Reset during the data bits of a frame.
    t0 = tb_cyc;
    tx_q.push_back(8'h3C);
    bus_write(A_TX, 32'h0000_003C);
    tx_q.push_back(8'h99);
    bus_write(A_TX, 32'h0000_0099);
    for (int n = 0; n < 100 && tb_cyc != t0 + 10; n++) @(negedge clk);
    resetn = 1'b0;
    tx_q.delete();
    @(negedge clk);
    check_val("midrst_txd", 64'(uart_txd), 64'h1);
    bus_read("midrst_status", A_ST, 32'h0000_0002);
    bus_read("midrst_led", A_LED, 32'h0);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check_val("midrst_no_frame", 64'(frames_rx), 64'd10);
    check_val("midrst_txd_idle", 64'(uart_txd), 64'h1);
    bus_read("midrst_ram_kept", 32'h0000_0010, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minicpu_data_responder.md
MINICPU_DATA_RESPONDER -- requirements
Module: minicpu_data_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, data RAM depth in 32-bit words.
REQ-002 Parameter CLK_DIV, default 16, clk cycles per UART bit; legal range 2..65535.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 data_sram_we  input  1  CPU write strobe for the current cycle.
REQ-006 data_sram_addr  input  32  CPU byte address, word-aligned; addr[1:0] ignored.
REQ-007 data_sram_wdata  input  32  CPU write data.
REQ-008 data_sram_rdata  output  32  read data for data_sram_addr, same cycle.
REQ-009 sw  input  8  board switches, sampled through a 2-flop synchroniser.
REQ-010 led  output  16  LED register.
REQ-011 uart_txd  output  1  serial transmit line, idle high.

Function
REQ-012 Address map SHALL be: 0x0000_0000..RAM_WORDS*4-1 RAM; 0xBFAF_0000 LED (RW); 0xBFAF_0004 SW (RO); 0xBFAF_0008 CYCLE (RO, write clears); 0xBFAF_000C TXDATA (WO); 0xBFAF_0010 STATUS (RO except bit3).
REQ-013 Reads SHALL be combinational from addr, with zero latency, because the CPU completes a load in one cycle.
REQ-014 Writes SHALL take effect at the rising edge when data_sram_we=1; a read in the following cycle returns the new value.
REQ-015 Unmapped reads, and reads of TXDATA, SHALL return 0; unmapped writes SHALL be ignored.
REQ-016 RAM index SHALL be addr[log2(RAM_WORDS)+1:2]; writes are full-word only.
REQ-017 LED read SHALL return {16'b0, led}; a write loads wdata[15:0].
REQ-018 SW read SHALL return {24'b0, sw_sync}, with 2-cycle synchroniser latency.
REQ-019 CYCLE SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF->0; a write sets it to 0 at that edge, and it increments from the next edge.
REQ-020 A TXDATA write SHALL push wdata[7:0] into an 8-entry FIFO when not full; when full, the push is dropped and sticky overflow is set.
REQ-021 STATUS SHALL read as {24'b0, count[3:0], overflow, busy, empty, full}; a write with wdata[3]=1 clears overflow.
REQ-022 Fullness SHALL be evaluated before the same-cycle pop: push and pop in the same cycle when count=8 drops the push; when count is 1..7 they leave count unchanged.
REQ-023 The TX FSM SHALL have states IDLE, START, DATA, STOP; busy=1 in any state other than IDLE.
REQ-024 In IDLE with FIFO non-empty, the FSM SHALL pop one byte and enter START the next cycle.
REQ-025 The FSM SHALL hold each of START (txd=0), the 8 DATA bits (LSB first) and STOP (txd=1) for exactly CLK_DIV cycles, giving 10*CLK_DIV cycles per frame.
REQ-026 From STOP, the FSM SHALL go to IDLE; when the FIFO is non-empty it pops in that IDLE cycle, so there is 1 idle cycle between frames.
REQ-027 The bit counter SHALL be 3 bits and the divider counter 16 bits; both reload to 0 on each state or bit change.

Reset
REQ-028 With resetn=0 at an edge: led=0, CYCLE=0, FIFO empty (count=0), overflow=0, FSM=IDLE, uart_txd=1, synchroniser=0.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 Reset mid-frame SHALL abort the frame; txd=1 from the first edge with resetn=0.
REQ-031 data_sram_rdata SHALL stay combinational during reset and reflect the reset register values.

Structure
REQ-032 Address constants, STATUS bit positions and FSM state encodings SHALL live in a shared package, minicpu_pkg.
REQ-033 The UART FIFO plus serialiser SHALL be one sub-module, minicpu_uart_tx; RAM, decode, LED, SW and CYCLE stay in the top.

Verification
REQ-034 Write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 the next cycle -> rdata=0x1234_5678; read 0x0000_0014 -> its prior contents, unchanged.
REQ-035 Write 0xFFFF_ABCD to LED -> led=0xABCD next cycle and LED read=0x0000_ABCD; read 0x8000_0000 -> 0.
REQ-036 Release reset, wait 100 cycles, write CYCLE, read 3 cycles later -> value 2; force CYCLE to 0xFFFF_FFFF -> reads 0 after one edge.
REQ-037 With CLK_DIV=4, write TXDATA 0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, start bit beginning 2 cycles after the write edge; STATUS busy=1 throughout the frame.
REQ-038 Write 10 bytes back-to-back while the first frame has not started -> 9 accepted, 1 dropped, overflow=1; write STATUS bit3 -> overflow=0; all 9 bytes transmitted in order.
REQ-039 Assert resetn=0 during the DATA state of a frame -> txd=1 immediately, STATUS reads 0x0000_0002 (empty only), no further frame emitted.
